// File: rtl/armleocpu_mem_1rwm_initiator.sv
// armleocpu_mem_1rwm_initiator
//   Sole master of a single-port (1RW, masked write) storage array. After
//   reset it optionally sweeps INIT_VALUE into every word, then converts a
//   client valid/ready request channel into memory read/write strobes and
//   returns read data on a valid/ready response channel.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   init_done             high once the sweep is finished (until next reset)
//   req_*                 client request channel (valid/ready, write, address,
//                         writedata, per-granule writeenable)
//   resp_*                client response channel (valid/ready, readdata)
//   address/read/write/   memory command outputs
//   writedata/writeenable
//   readdata              memory read data, valid the cycle after a read
//
// WIDTH must be an exact multiple of GRANULITY.

module armleocpu_mem_1rwm_initiator #(
  parameter int ELEMENTS_W = 3,
  parameter int WIDTH = 32,
  parameter int GRANULITY = 8,
  localparam int ENABLES = WIDTH / GRANULITY,
  parameter bit INIT_ON_RESET = 1'b1,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_done,

  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ELEMENTS_W-1:0] req_address,
  input  logic [WIDTH-1:0]      req_writedata,
  input  logic [ENABLES-1:0]    req_writeenable,

  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDTH-1:0]      resp_readdata,

  output logic [ELEMENTS_W-1:0] address,
  output logic                  read,
  output logic                  write,
  output logic [WIDTH-1:0]      writedata,
  output logic [ENABLES-1:0]    writeenable,
  input  logic [WIDTH-1:0]      readdata
);

  typedef enum logic [1:0] {
    START,
    INIT,
    RUN
  } state_t;

  // The sweep counter has one spare bit so the last address is reached
  // without the counter wrapping back to zero first.
  localparam logic [ELEMENTS_W:0] LAST_ADDR = {1'b0, {ELEMENTS_W{1'b1}}};
  localparam logic [ELEMENTS_W:0] CNT_ONE   = {{ELEMENTS_W{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ELEMENTS_W:0]   counter_q, counter_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  init_done_q, init_done_d;
  logic                  run_ready;

  // A stalled response blocks further reads (readdata must stay put), but
  // writes never disturb readdata so they are always accepted.
  assign run_ready = req_write ? 1'b1 : (!resp_valid_q || resp_ready);

  // Memory command outputs: sweep writes during INIT, straight pass-through
  // of the client request during RUN, idle otherwise.
  always_comb begin
    address     = req_address;
    writedata   = req_writedata;
    writeenable = req_writeenable;
    read        = 1'b0;
    write       = 1'b0;
    req_ready   = 1'b0;
    case (state_q)
      INIT: begin
        write       = 1'b1;
        address     = counter_q[ELEMENTS_W-1:0];
        writedata   = INIT_VALUE;
        writeenable = '1;
      end
      RUN: begin
        req_ready = run_ready;
        read      = req_valid && run_ready && !req_write;
        write     = req_valid && run_ready && req_write;
      end
      default: ;
    endcase
  end

  // Next-state logic for the controller state, sweep counter and the
  // registered response/init flags.
  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    resp_valid_d = resp_valid_q;
    init_done_d  = init_done_q;
    case (state_q)
      START: begin
        if (INIT_ON_RESET) begin
          state_d = INIT;
        end else begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      INIT: begin
        counter_d = counter_q + CNT_ONE;
        if (counter_q == LAST_ADDR) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        // A new read keeps resp_valid high even if the current one is
        // consumed this cycle, giving one response per cycle.
        if (read) begin
          resp_valid_d = 1'b1;
        end else if (resp_ready) begin
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = START;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= START;
      counter_q    <= '0;
      resp_valid_q <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      resp_valid_q <= resp_valid_d;
      init_done_q  <= init_done_d;
    end
  end

  assign resp_valid    = resp_valid_q;
  assign init_done     = init_done_q;
  assign resp_readdata = readdata;

endmodule

// File: tb/tb_armleocpu_mem_1rwm_initiator.sv
// tb_armleocpu_mem_1rwm_initiator
//   Testbench for armleocpu_mem_1rwm_initiator with ELEMENTS_W=3, WIDTH=32,
//   GRANULITY=8, INIT_VALUE=0. Includes a behavioural 1RW masked memory.

module tb_armleocpu_mem_1rwm_initiator;

  logic        clk;
  logic        rst_n;
  logic        init_done;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_address;
  logic [31:0] req_writedata;
  logic [3:0]  req_writeenable;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_readdata;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  writeenable;
  logic [31:0] readdata;

  typedef struct {
    logic        isWrite;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wen;
    logic [31:0] expData;
  } vec_t;

  vec_t        vectors[$];
  logic [31:0] mem [8];
  logic [31:0] shadow [8];
  int          errors = 0;
  int          checks = 0;

  armleocpu_mem_1rwm_initiator #(
    .ELEMENTS_W(3),
    .WIDTH(32),
    .GRANULITY(8),
    .INIT_ON_RESET(1'b1),
    .INIT_VALUE(32'h0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .init_done(init_done),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_address(req_address),
    .req_writedata(req_writedata),
    .req_writeenable(req_writeenable),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_readdata(resp_readdata),
    .address(address),
    .read(read),
    .write(write),
    .writedata(writedata),
    .writeenable(writeenable),
    .readdata(readdata)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Storage array: masked byte writes, readdata registered on a read and
  // held otherwise. Starts with a non-zero pattern so the sweep is visible.
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'hA5A50000 | 32'(i);
    readdata = 32'h0;
  end

  always @(posedge clk) begin
    if (write) begin
      for (int g = 0; g < 4; g++) begin
        if (writeenable[g]) mem[address][g*8 +: 8] <= writedata[g*8 +: 8];
      end
    end
    if (read) readdata <= mem[address];
  end

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] mergeWrite(input logic [31:0] old,
                                             input logic [31:0] data,
                                             input logic [3:0] en);
    logic [31:0] r;
    r = old;
    for (int g = 0; g < 4; g++) begin
      if (en[g]) r[g*8 +: 8] = data[g*8 +: 8];
    end
    return r;
  endfunction

  function automatic vec_t mkVec(input logic w, input logic [2:0] a,
                                 input logic [31:0] d, input logic [3:0] e,
                                 input logic [31:0] x);
    vec_t v;
    v.isWrite = w;
    v.addr    = a;
    v.wdata   = d;
    v.wen     = e;
    v.expData = x;
    return v;
  endfunction

  task automatic checkWord(input string name, input logic [31:0] actual,
                           input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic actual,
                             input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic w, input logic [2:0] a,
                               input logic [31:0] d, input logic [3:0] e);
    req_valid       = v;
    req_write       = w;
    req_address     = a;
    req_writedata   = d;
    req_writeenable = e;
  endtask

  // Assert reset, check the idle outputs, then release it just after an edge
  // so the following cycle is the single START cycle.
  task automatic releaseReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    resp_ready = 1'b0;
    @(negedge clk);
    checkOutput("rst_read", read, 1'b0);
    checkOutput("rst_write", write, 1'b0);
    checkOutput("rst_req_ready", req_ready, 1'b0);
    checkOutput("rst_resp_valid", resp_valid, 1'b0);
    checkOutput("rst_init_done", init_done, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("start_write", write, 1'b0);
    checkOutput("start_req_ready", req_ready, 1'b0);
  endtask

  // Follow the sweep cycle by cycle; abortAt >= 0 pulls reset in the middle
  // of that sweep cycle and checks the strobes drop at once.
  task automatic checkSweep(input int abortAt);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("sweep_write", write, 1'b1);
      checkOutput("sweep_read", read, 1'b0);
      checkWord("sweep_address", 32'(address), 32'(i));
      checkWord("sweep_writedata", writedata, 32'h0);
      checkWord("sweep_writeenable", 32'(writeenable), 32'hF);
      checkOutput("sweep_req_ready", req_ready, 1'b0);
      checkOutput("sweep_init_done", init_done, 1'b0);
      if (i == abortAt) begin
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_write", write, 1'b0);
        checkOutput("abort_read", read, 1'b0);
        checkOutput("abort_req_ready", req_ready, 1'b0);
        return;
      end
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("sweep_init_done_end", init_done, 1'b1);
    checkOutput("sweep_idle_write", write, 1'b0);
    checkOutput("sweep_idle_req_ready", req_ready, 1'b1);
    for (int i = 0; i < 8; i++) shadow[i] = 32'h0;
  endtask

  // One table entry: a write takes one accepted cycle, a read takes the
  // accepted cycle plus the response cycle (resp_ready held high).
  task automatic doVector(input vec_t v);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, v.isWrite, v.addr, v.wdata, v.wen);
    resp_ready = 1'b1;
    @(negedge clk);
    checkOutput("vec_req_ready", req_ready, 1'b1);
    checkWord("vec_address", 32'(address), 32'(v.addr));
    if (v.isWrite) begin
      checkOutput("vec_write", write, 1'b1);
      checkOutput("vec_read", read, 1'b0);
      checkWord("vec_writedata", writedata, v.wdata);
      checkWord("vec_writeenable", 32'(writeenable), 32'(v.wen));
      shadow[v.addr] = mergeWrite(shadow[v.addr], v.wdata, v.wen);
    end else begin
      checkOutput("vec_read", read, 1'b1);
      checkOutput("vec_write", write, 1'b0);
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
      @(negedge clk);
      checkOutput("vec_resp_valid", resp_valid, 1'b1);
      checkWord("vec_resp_data", resp_readdata, v.expData);
    end
  endtask

  initial begin
    logic        mrv;
    logic [31:0] mdata;
    logic        expReady;
    logic        accepted;

    rst_n = 1'b0;
    resp_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);

    // Directed vectors: read back the cleared array, masked writes,
    // read-after-write in consecutive cycles.
    for (int i = 0; i < 8; i++) vectors.push_back(mkVec(1'b0, 3'(i), 32'h0, 4'h0, 32'h0));
    vectors.push_back(mkVec(1'b1, 3'd3, 32'hDEADBEEF, 4'hF, 32'h0));
    vectors.push_back(mkVec(1'b1, 3'd3, 32'h11223344, 4'h5, 32'h0));
    vectors.push_back(mkVec(1'b0, 3'd3, 32'h0, 4'h0, 32'hDE22BE44));
    vectors.push_back(mkVec(1'b1, 3'd5, 32'hCAFEF00D, 4'hC, 32'h0));
    vectors.push_back(mkVec(1'b0, 3'd5, 32'h0, 4'h0, 32'hCAFE0000));
    vectors.push_back(mkVec(1'b1, 3'd6, 32'h12345678, 4'h3, 32'h0));
    vectors.push_back(mkVec(1'b0, 3'd6, 32'h0, 4'h0, 32'h00005678));
    vectors.push_back(mkVec(1'b0, 3'd3, 32'h0, 4'h0, 32'hDE22BE44));

    $display("[TB] reset and initial sweep");
    releaseReset();
    checkSweep(-1);

    $display("[TB] directed vectors");
    foreach (vectors[k]) doVector(vectors[k]);

    // Stalled response: reads are refused, a write still goes through and
    // the held read data does not change.
    $display("[TB] stalled response");
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 3'd3, 32'h0, 4'h0);
    resp_ready = 1'b0;
    @(negedge clk);
    checkOutput("stall_first_read", read, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (c == 0)      applyStimulus(1'b1, 1'b0, 3'd3, 32'h0, 4'h0);
      else if (c == 1) applyStimulus(1'b1, 1'b1, 3'd3, 32'h0, 4'hF);
      else             applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
      @(negedge clk);
      checkOutput("stall_resp_valid", resp_valid, 1'b1);
      checkWord("stall_resp_data", resp_readdata, 32'hDE22BE44);
      if (c == 0) begin
        checkOutput("stall_read_ready", req_ready, 1'b0);
        checkOutput("stall_read_blocked", read, 1'b0);
      end else if (c == 1) begin
        checkOutput("stall_write_ready", req_ready, 1'b1);
        checkOutput("stall_write", write, 1'b1);
        shadow[3] = 32'h0;
      end
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(negedge clk);
    checkOutput("stall_release_valid", resp_valid, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("stall_consumed", resp_valid, 1'b0);
    doVector(mkVec(1'b0, 3'd3, 32'h0, 4'h0, 32'h0));

    // Back-to-back reads, one per cycle, after filling distinct values.
    $display("[TB] back-to-back reads");
    for (int i = 0; i < 8; i++)
      doVector(mkVec(1'b1, 3'(i), 32'hC0DE0000 + 32'(i) * 32'h111, 4'hF, 32'h0));
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      applyStimulus(1'b1, 1'b0, 3'(i), 32'h0, 4'h0);
      resp_ready = 1'b1;
      @(negedge clk);
      checkOutput("b2b_req_ready", req_ready, 1'b1);
      checkOutput("b2b_read", read, 1'b1);
      if (i > 0) begin
        checkOutput("b2b_resp_valid", resp_valid, 1'b1);
        checkWord("b2b_resp_data", resp_readdata, 32'hC0DE0000 + 32'(i - 1) * 32'h111);
      end
    end
    @(posedge clk);
    #1 applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("b2b_last_valid", resp_valid, 1'b1);
    checkWord("b2b_last_data", resp_readdata, 32'hC0DE0777);
    @(posedge clk);
    @(negedge clk);
    checkOutput("b2b_drained", resp_valid, 1'b0);

    // Reset with a response pending, then reset again mid-sweep.
    $display("[TB] reset during response and sweep");
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 3'd2, 32'h0, 4'h0);
    resp_ready = 1'b0;
    @(posedge clk);
    #1 applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("pend_resp_valid", resp_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("pend_dropped", resp_valid, 1'b0);
    checkOutput("pend_init_done", init_done, 1'b0);
    releaseReset();
    checkSweep(3);
    releaseReset();
    checkSweep(-1);

    // Random traffic against a reference model of the channel protocol.
    $display("[TB] random traffic");
    mrv = 1'b0;
    mdata = 32'h0;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk);
      #1;
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    3'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
      resp_ready = $urandom_range(0, 2) != 0;
      @(negedge clk);
      expReady = req_write ? 1'b1 : (!mrv || resp_ready);
      accepted = req_valid && expReady;
      checkOutput("rnd_req_ready", req_ready, expReady);
      checkOutput("rnd_rw_exclusive", read && write, 1'b0);
      checkOutput("rnd_read", read, accepted && !req_write);
      checkOutput("rnd_write", write, accepted && req_write);
      checkOutput("rnd_resp_valid", resp_valid, mrv);
      if (mrv) checkWord("rnd_resp_data", resp_readdata, mdata);
      if (accepted && req_write)
        shadow[req_address] = mergeWrite(shadow[req_address], req_writedata, req_writeenable);
      if (accepted && !req_write) begin
        mrv = 1'b1;
        mdata = shadow[req_address];
      end else if (resp_ready) begin
        mrv = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/armleocpu_mem_1rwm_initiator.md
Name: armleocpu_mem_1rwm_initiator

Overview:
- Initiator-side controller that drives one armleocpu_mem_1rwm port (address/read/write/writedata/writeenable in, readdata out).
- Clears the whole array after reset, then converts a client valid/ready request channel into memory commands and returns read data on a valid/ready response channel.
- Sits between cache/TLB logic and its storage array; it is the only master of that array.

Parameters:
- ELEMENTS_W, 3: address width; depth = 2**ELEMENTS_W.
- WIDTH, 32: data width.
- GRANULITY, 8: bits per write-enable; ENABLES = WIDTH/GRANULITY; WIDTH must be divisible by GRANULITY.
- INIT_ON_RESET, 1: 1 = sweep-write INIT_VALUE to every word after reset; 0 = skip the sweep.
- INIT_VALUE, 0: WIDTH-bit value written during the sweep.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- init_done  out  1  high once the sweep has finished; stays high until the next reset.
- req_valid  in  1  client request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_address  in  ELEMENTS_W  word address.
- req_writedata  in  WIDTH  write data.
- req_writeenable  in  ENABLES  per-granule write enables.
- resp_valid  out  1  read data valid.
- resp_ready  in  1  client consumes the response.
- resp_readdata  out  WIDTH  read result.
- address  out  ELEMENTS_W  memory address.
- read  out  1  memory read strobe.
- write  out  1  memory write strobe.
- writedata  out  WIDTH  memory write data.
- writeenable  out  ENABLES  memory write enables.
- readdata  in  WIDTH  memory read data.

Behaviour:
- Memory contract:
  - readdata is valid the cycle after a read strobe.
  - readdata holds its value until the next read, including across writes.
  - read and write are never asserted together.
- States: START, INIT, RUN.
  - Asynchronous reset value: START, sweep counter 0, resp_valid 0, init_done 0.
  - While rst_n is low or the state is START: read=0, write=0, req_ready=0.
- START to next state (one cycle): INIT if INIT_ON_RESET=1, else RUN.
- INIT:
  - Each cycle: write=1, address=counter, writedata=INIT_VALUE, writeenable all ones; counter increments.
  - After the write to address 2**ELEMENTS_W-1, go to RUN.
  - Sweep length is exactly 2**ELEMENTS_W cycles; the counter is ELEMENTS_W+1 bits so the last address does not wrap early.
  - req_ready=0 throughout.
- RUN:
  - init_done=1; it is a registered output and rises on the edge that enters RUN.
  - req_ready = req_write ? 1 : (!resp_valid || resp_ready).
  - Writes are always accepted, including while a response is stalled.
  - Memory outputs are combinational pass-through of the request:
    - address = req_address.
    - read = req_valid && req_ready && !req_write.
    - write = req_valid && req_ready && req_write.
    - writedata = req_writedata, writeenable = req_writeenable.
  - An accepted read sets resp_valid on the next edge.
  - resp_valid clears on the edge where resp_valid && resp_ready and no new read is accepted.
  - If a new read is accepted in the same cycle the response is consumed, resp_valid stays 1 (back-to-back reads, one per cycle).
  - resp_readdata = readdata (combinational). It is stable while resp_valid && !resp_ready, because no read is issued during a stall.
- Writes produce no response.
- Request fields are don't-care when req_valid=0. With req_valid=0, read=write=0.
- Read-after-write to the same address in consecutive accepted cycles returns the new data (write, then read, then data next cycle).
- Reset mid-sweep or mid-response:
  - Returns immediately to START with resp_valid=0 and init_done=0.
  - The sweep restarts from address 0.
  - Any pending response is dropped.

Test Plan (ELEMENTS_W=3, WIDTH=32, GRANULITY=8, INIT_VALUE=0):
1. Release reset -> one START cycle, then exactly 8 INIT cycles writing addresses 0..7 with 0 and writeenable 0xF; init_done rises after the 8th write; reads of addresses 0..7 return 0.
2. Write addr 3 = 0xDEADBEEF, enables 0xF; then write addr 3 = 0x11223344, enables 0x5; read addr 3 -> resp_valid next cycle with 0xDE22BE44.
3. Read addr 3 with resp_ready=0 for 5 cycles, issuing a write to addr 3 of 0 meanwhile -> resp_readdata stays 0xDE22BE44, req_ready=0 for reads, write accepted; resp_ready=1 -> consumed; a re-read returns 0.
4. Back-to-back reads of addr 0..7 with resp_ready held at 1 -> req_ready stays 1, 8 responses on consecutive cycles, in order, each matching the shadow model.
5. Assert rst_n=0 on the 4th sweep cycle -> read/write drop to 0 immediately; after release a full 8-cycle sweep restarts at address 0.
6. 1000 random read/write/enable operations with random resp_ready -> every response matches a reference model that applies per-granule enables; read and write are never high together.
